// File: rtl/alarm_controller.sv
// Alarm compare and buzzer sequencer: IDLE / RINGING / SNOOZE driven by the 1 Hz Sec_Tick.
// Define ALARM_BEEP_EN for a 1 s on / 1 s off buzzer; otherwise the buzzer is a steady tone.
module alarm_controller #(
  parameter int unsigned SNOOZE_MIN = 5,
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned MAX_SNOOZE = 3
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic        Sec_Tick,
  input  logic [1:0]  HR_T,
  input  logic [3:0]  HR_U,
  input  logic [2:0]  MIN_T,
  input  logic [3:0]  MIN_U,
  input  logic        LD_Alm,
  input  logic [1:0]  ALM_HR_T,
  input  logic [3:0]  ALM_HR_U,
  input  logic [2:0]  ALM_MIN_T,
  input  logic [3:0]  ALM_MIN_U,
  input  logic        Alm_En,
  input  logic        Snooze,
  input  logic        Stop,
  output logic        Buzzer,
  output logic        Ringing,
  output logic        Snoozing,
  output logic [12:0] ALM_OUT
);

  localparam logic [9:0] SnzLoad  = 10'(SNOOZE_MIN * 60);
  localparam logic [7:0] RingLast = 8'(RING_SEC - 1);
  localparam logic [2:0] SnzMax   = 3'(MAX_SNOOZE);

  typedef enum logic [1:0] {StIdle, StRinging, StSnooze} state_e;

  state_e      state_q, state_d;
  logic [12:0] alm_q;
  logic        match, match_q, trigger;
  logic [7:0]  ring_cnt_q, ring_cnt_d;
  logic [9:0]  snz_timer_q, snz_timer_d;
  logic [2:0]  snz_cnt_q, snz_cnt_d;
  logic        snooze_ok;

  // Alarm registers; out-of-range digits are kept as-is and simply never match.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      alm_q <= '0;
    end else if (LD_Alm) begin
      alm_q <= {ALM_HR_T, ALM_HR_U, ALM_MIN_T, ALM_MIN_U};
    end
  end

  assign match = ({HR_T, HR_U, MIN_T, MIN_U} == alm_q);

  // match_q resets high so a time already equal to the alarm at reset is not an edge.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      match_q <= 1'b1;
    end else begin
      match_q <= match;
    end
  end

  assign trigger   = match & ~match_q & Alm_En;
  assign snooze_ok = Snooze && (snz_cnt_q < SnzMax);

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state_q     <= StIdle;
      ring_cnt_q  <= '0;
      snz_timer_q <= '0;
      snz_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      ring_cnt_q  <= ring_cnt_d;
      snz_timer_q <= snz_timer_d;
      snz_cnt_q   <= snz_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ring_cnt_d  = ring_cnt_q;
    snz_timer_d = snz_timer_q;
    snz_cnt_d   = snz_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (trigger) begin
          state_d    = StRinging;
          ring_cnt_d = '0;
          snz_cnt_d  = '0;
        end
      end
      StRinging: begin
        if (Stop || !Alm_En) begin
          state_d = StIdle;
        end else if (snooze_ok) begin
          state_d     = StSnooze;
          snz_timer_d = SnzLoad;
          snz_cnt_d   = snz_cnt_q + 3'd1;
        end else if (Sec_Tick) begin
          if (ring_cnt_q == RingLast) begin
            state_d = StIdle;
          end else begin
            ring_cnt_d = ring_cnt_q + 8'd1;
          end
        end
      end
      StSnooze: begin
        if (Stop || !Alm_En) begin
          state_d = StIdle;
        end else if (Sec_Tick) begin
          if (snz_timer_q == 10'd1) begin
            state_d    = StRinging;
            ring_cnt_d = '0;
          end else begin
            snz_timer_d = snz_timer_q - 10'd1;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Decoded straight from the state flop so Clr silences the outputs without a clock edge.
  assign Ringing  = (state_q == StRinging);
  assign Snoozing = (state_q == StSnooze);
  assign ALM_OUT  = alm_q;

`ifdef ALARM_BEEP_EN
  logic beep_ph_q;

  // Phase restarts on every entry to RINGING so each ring begins with the tone on.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      beep_ph_q <= 1'b0;
    end else if ((state_d == StRinging) && (state_q != StRinging)) begin
      beep_ph_q <= 1'b0;
    end else if ((state_q == StRinging) && Sec_Tick) begin
      beep_ph_q <= ~beep_ph_q;
    end
  end

  assign Buzzer = Ringing & ~beep_ph_q;
`else
  assign Buzzer = Ringing;
`endif

endmodule

// File: tb/tb_alarm_controller.sv
// Self-checking bench for alarm_controller: randomized stimulus against a countdown-based model.
module tb_alarm_controller;

  localparam int unsigned SNOOZE_MIN = 5;
  localparam int unsigned RING_SEC   = 60;
  localparam int unsigned MAX_SNOOZE = 3;
  localparam int          SNZ_TICKS  = SNOOZE_MIN * 60;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        tick = 1'b0;
  logic        ld = 1'b0;
  logic        en = 1'b0;
  logic        snooze = 1'b0;
  logic        stop = 1'b0;
  int          tm = 0;
  logic [12:0] alm_in = '0;

  logic [1:0]  hr_t, alm_hr_t;
  logic [3:0]  hr_u, alm_hr_u;
  logic [2:0]  min_t, alm_min_t;
  logic [3:0]  min_u, alm_min_u;
  logic        buzzer, ringing, snoozing;
  logic [12:0] alm_out;
  logic [15:0] dut_vec;

  int checks = 0;
  int fails  = 0;

  // Reference model: remaining-tick countdowns rather than count-up registers.
  bit          m_ring, m_snz, m_beep, m_prev_match;
  int          m_ring_left, m_snz_left, m_used;
  logic [12:0] m_alm;

  always #5 clk = ~clk;

  function automatic logic [12:0] time_digits(int t);
    return {2'(t / 600), 4'((t / 60) % 10), 3'((t % 60) / 10), 4'(t % 10)};
  endfunction

  assign {hr_t, hr_u, min_t, min_u} = time_digits(tm);
  assign {alm_hr_t, alm_hr_u, alm_min_t, alm_min_u} = alm_in;
  assign dut_vec = {ringing, snoozing, buzzer, alm_out};

  alarm_controller #(
    .SNOOZE_MIN(SNOOZE_MIN),
    .RING_SEC  (RING_SEC),
    .MAX_SNOOZE(MAX_SNOOZE)
  ) dut (
    .Clk      (clk),
    .Clr      (clr),
    .Sec_Tick (tick),
    .HR_T     (hr_t),
    .HR_U     (hr_u),
    .MIN_T    (min_t),
    .MIN_U    (min_u),
    .LD_Alm   (ld),
    .ALM_HR_T (alm_hr_t),
    .ALM_HR_U (alm_hr_u),
    .ALM_MIN_T(alm_min_t),
    .ALM_MIN_U(alm_min_u),
    .Alm_En   (en),
    .Snooze   (snooze),
    .Stop     (stop),
    .Buzzer   (buzzer),
    .Ringing  (ringing),
    .Snoozing (snoozing),
    .ALM_OUT  (alm_out)
  );

  task automatic model_reset();
    m_ring = 0; m_snz = 0; m_beep = 0; m_prev_match = 1;
    m_ring_left = 0; m_snz_left = 0; m_used = 0; m_alm = '0;
  endtask

  // Applies one clock edge to the model using the inputs currently driven.
  task automatic model_edge();
    bit mt, trig;
    mt   = (time_digits(tm) == m_alm);
    trig = mt && !m_prev_match && en;
    if (m_ring) begin
      if (stop || !en) m_ring = 0;
      else if (snooze && m_used < int'(MAX_SNOOZE)) begin
        m_ring = 0; m_snz = 1; m_snz_left = SNZ_TICKS; m_used++;
      end else if (tick) begin
        m_ring_left--;
        if (m_ring_left == 0) m_ring = 0;
        else m_beep = !m_beep;
      end
    end else if (m_snz) begin
      if (stop || !en) m_snz = 0;
      else if (tick) begin
        m_snz_left--;
        if (m_snz_left == 0) begin
          m_snz = 0; m_ring = 1; m_ring_left = RING_SEC; m_beep = 0;
        end
      end
    end else if (trig) begin
      m_ring = 1; m_ring_left = RING_SEC; m_used = 0; m_beep = 0;
    end
    m_prev_match = mt;
    if (ld) m_alm = alm_in;
  endtask

  function automatic logic [15:0] exp_vec();
    logic buz;
`ifdef ALARM_BEEP_EN
    buz = m_ring & ~m_beep;
`else
    buz = m_ring;
`endif
    return {m_ring, m_snz, buz, m_alm};
  endfunction

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  // Brings the alarm (07:30) to a fresh ring from any state.
  task automatic ring_up();
    tick = 0; snooze = 0; stop = 1; step();
    stop = 0; tm = 451; step();
    tm = 450; step();
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    model_reset();
    checks++;
    if (dut_vec !== 16'd0) begin
      $display("FAIL reset_outs: got %h want %h", dut_vec, 16'd0); fails++;
    end
    #2 clr = 0;
    en = 1; tm = 0;
    for (int i = 0; i < 20; i++) begin
      tick = 1'($urandom_range(0, 1));
      step();
      checks++;
      if (dut_vec !== exp_vec() || ringing !== 1'b0) begin
        $display("FAIL reset_hold_0000: got %h want %h", dut_vec, exp_vec()); fails++;
      end
    end
  endtask

  task automatic test_basic_ring();
    logic [12:0] exp_alm;
    int nt;
    exp_alm = {2'd0, 4'd7, 3'd3, 4'd0};
    tick = 0; tm = 449; alm_in = exp_alm; ld = 1; step();
    ld = 0;
    checks++;
    if (alm_out !== exp_alm || ringing !== 1'b0) begin
      $display("FAIL load_0730: got %h/%b want %h/0", alm_out, ringing, exp_alm); fails++;
    end
    step();
    tm = 450; step();
    checks++;
    if ({ringing, buzzer} !== 2'b11 || dut_vec !== exp_vec()) begin
      $display("FAIL ring_on_match: got %h want %h", dut_vec, exp_vec()); fails++;
    end
    nt = 0;
    for (int i = 0; i < 2000 && nt < int'(RING_SEC); i++) begin
      tick = ($urandom_range(0, 2) == 0);
      step();
      if (tick) nt++;
      checks++;
      if (ringing !== (nt < int'(RING_SEC)) || dut_vec !== exp_vec()) begin
        $display("FAIL auto_stop: ticks %0d got %h want %h", nt, dut_vec, exp_vec()); fails++;
      end
    end
    if (nt < int'(RING_SEC)) begin
      checks++; fails++;
      $display("FAIL auto_stop_timeout: got %0d ticks want %0d", nt, RING_SEC);
    end
    tick = 0;
    for (int i = 0; i < 10; i++) begin
      tick = 1'($urandom_range(0, 1));
      step();
      checks++;
      if (ringing !== 1'b0 || dut_vec !== exp_vec()) begin
        $display("FAIL no_retrigger: got %h want %h", dut_vec, exp_vec()); fails++;
      end
    end
  endtask

  task automatic test_snooze();
    int nt;
    ring_up();
    for (int s = 0; s < int'(MAX_SNOOZE); s++) begin
      snooze = 1; step();
      snooze = 0;
      checks++;
      if ({ringing, snoozing, buzzer} !== 3'b010 || dut_vec !== exp_vec()) begin
        $display("FAIL snooze_enter: got %h want %h", dut_vec, exp_vec()); fails++;
      end
      nt = 0;
      for (int i = 0; i < 3000 && nt < SNZ_TICKS; i++) begin
        tick = 1'($urandom_range(0, 1));
        snooze = ($urandom_range(0, 3) == 0);
        step();
        if (tick) nt++;
        checks++;
        if (snoozing !== (nt < SNZ_TICKS) || dut_vec !== exp_vec()) begin
          $display("FAIL snooze_len: ticks %0d got %h want %h", nt, dut_vec, exp_vec()); fails++;
        end
      end
      tick = 0; snooze = 0;
      checks++;
      if (ringing !== 1'b1) begin
        $display("FAIL re_ring: got %b want 1 after %0d ticks", ringing, nt); fails++;
      end
    end
    snooze = 1; step();
    snooze = 0;
    checks++;
    if ({ringing, snoozing} !== 2'b10 || dut_vec !== exp_vec()) begin
      $display("FAIL snooze_exhausted: got %h want %h", dut_vec, exp_vec()); fails++;
    end
  endtask

  task automatic test_stop_wins();
    ring_up();
    snooze = 1; stop = 1; step();
    snooze = 0; stop = 0;
    checks++;
    if ({ringing, snoozing} !== 2'b00 || dut_vec !== exp_vec()) begin
      $display("FAIL stop_and_snooze: got %h want %h", dut_vec, exp_vec()); fails++;
    end
    ring_up();
    snooze = 1; step();
    snooze = 0;
    for (int i = 0; i < 400 && m_snz_left > 1; i++) begin
      tick = 1; step();
    end
    tick = 1; stop = 1; step();
    tick = 0; stop = 0;
    checks++;
    if ({ringing, snoozing} !== 2'b00 || dut_vec !== exp_vec()) begin
      $display("FAIL stop_vs_expiry: got %h want %h", dut_vec, exp_vec()); fails++;
    end
  endtask

  task automatic test_enable();
    tick = 0; stop = 1; step();
    stop = 0; tm = 451; step();
    en = 0; tm = 450; step();
    checks++;
    if (ringing !== 1'b0 || dut_vec !== exp_vec()) begin
      $display("FAIL disabled_match: got %h want %h", dut_vec, exp_vec()); fails++;
    end
    en = 1;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (ringing !== 1'b0 || dut_vec !== exp_vec()) begin
      $display("FAIL late_enable: got %h want %h", dut_vec, exp_vec()); fails++;
    end
    ring_up();
    snooze = 1; step();
    snooze = 0; en = 0; step();
    en = 1;
    checks++;
    if ({ringing, snoozing} !== 2'b00 || dut_vec !== exp_vec()) begin
      $display("FAIL disable_in_snooze: got %h want %h", dut_vec, exp_vec()); fails++;
    end
  endtask

  task automatic test_load_equal();
    logic [12:0] t10;
    t10 = time_digits(600);
    tm = 600; step();
    alm_in = t10; ld = 1; step();
    ld = 0;
    checks++;
    if (alm_out !== t10 || ringing !== 1'b0) begin
      $display("FAIL load_equal_store: got %h/%b want %h/0", alm_out, ringing, t10); fails++;
    end
    step();
    checks++;
    if (ringing !== 1'b1 || dut_vec !== exp_vec()) begin
      $display("FAIL load_equal_ring: got %h want %h", dut_vec, exp_vec()); fails++;
    end
    alm_in = time_digits(450); ld = 1; stop = 1; step();
    ld = 0; stop = 0;
  endtask

  task automatic test_clr_mid_ring();
    ring_up();
    #3 clr = 1;
    #1;
    model_reset();
    checks++;
    if ({ringing, snoozing, buzzer, alm_out} !== 16'd0) begin
      $display("FAIL async_clr: got %h want %h", dut_vec, 16'd0); fails++;
    end
    #2 clr = 0;
    tm = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (ringing !== 1'b0 || dut_vec !== exp_vec()) begin
        $display("FAIL clr_hold_0000: got %h want %h", dut_vec, exp_vec()); fails++;
      end
    end
  endtask

  task automatic test_random();
    int          times[5];
    logic [12:0] alarms[4];
    times  = '{450, 451, 600, 601, 0};
    alarms = '{time_digits(450), time_digits(600), time_digits(601), 13'h0F3F};
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) tm = times[$urandom_range(0, 4)];
      ld     = ($urandom_range(0, 63) == 0);
      alm_in = alarms[$urandom_range(0, 3)];
      en     = ($urandom_range(0, 15) != 0);
      snooze = ($urandom_range(0, 15) == 0);
      stop   = ($urandom_range(0, 63) == 0);
      tick   = ($urandom_range(0, 3) == 0);
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        $display("FAIL random_%0d: got %h want %h", i, dut_vec, exp_vec()); fails++;
      end
    end
    ld = 0; snooze = 0; stop = 0; tick = 0; en = 1;
  endtask

  initial begin
    test_reset();
    test_basic_ring();
    test_snooze();
    test_stop_wins();
    test_enable();
    test_load_equal();
    test_clr_mid_ring();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule

// File: doc/alarm_controller.md
Name: alarm_controller

Overview:
- Downstream consumer of the HH:MM digit counters (hours BCD, minutes tens 0-5, minutes units 0-9).
- Holds the programmed alarm time and compares it against the live time.
- A 3-state FSM drives the buzzer, handling snooze, stop and auto-timeout.
- The 1 Hz enable pulse, the same one that advances the seconds counters, is the only time base.

Parameters:
SNOOZE_MIN, 5, snooze length in minutes (1-15)
RING_SEC, 60, seconds of ringing before auto-stop (1-255)
MAX_SNOOZE, 3, snoozes allowed per alarm event (0-7); 0 disables snooze

Ports:
Clk  input  1  system clock, rising edge
Clr  input  1  asynchronous reset, active-high
Sec_Tick  input  1  one-Clk-wide 1 Hz enable pulse
HR_T  input  2  current hour tens, BCD 0-2
HR_U  input  4  current hour units, BCD 0-9
MIN_T  input  3  current minute tens, 0-5
MIN_U  input  4  current minute units, BCD 0-9
LD_Alm  input  1  load alarm registers from the ALM_* inputs
ALM_HR_T  input  2  alarm hour tens to load
ALM_HR_U  input  4  alarm hour units to load
ALM_MIN_T  input  3  alarm minute tens to load
ALM_MIN_U  input  4  alarm minute units to load
Alm_En  input  1  alarm armed (level)
Snooze  input  1  snooze request, synchronous, sampled each Clk
Stop  input  1  stop request, synchronous, sampled each Clk
Buzzer  output  1  buzzer drive
Ringing  output  1  high in RINGING
Snoozing  output  1  high in SNOOZE
ALM_OUT  output  13  stored alarm {hr_t,hr_u,min_t,min_u}

Behaviour:
- Clock and reset: single clock Clk. Clr is asynchronous, active-high. Clr asserted forces:
  - state IDLE, alarm registers 00:00 (ALM_OUT=0);
  - Buzzer=0, Ringing=0, Snoozing=0;
  - snooze count 0, timers 0, match_q=1.
- Reset mid-operation: Clr during RINGING or SNOOZE silences the buzzer immediately, with no Clk edge needed.
- LD_Alm:
  - On a Clk edge with LD_Alm=1, the alarm registers capture ALM_*. Loaded values show on ALM_OUT next cycle.
  - Loading is allowed in any state and never changes state.
  - Out-of-range BCD digits are stored unchanged and simply never match.
- Match and trigger:
  - match = (HR_T,HR_U,MIN_T,MIN_U) equal to the alarm registers, combinational.
  - match_q registers match every Clk.
  - trigger = match & ~match_q & Alm_En, i.e. the rising edge of match.
  - match_q resets to 1, so a time equal to the alarm at reset does not trigger.
  - Loading an alarm equal to the current time does trigger, one Clk after the load takes effect.
- FSM states: IDLE, RINGING, SNOOZE.
- IDLE:
  - trigger -> RINGING; clear ring_cnt and snooze count.
  - Stop and Snooze are ignored.
- RINGING, evaluated in this priority:
  1. Stop=1 or Alm_En=0 -> IDLE.
  2. Snooze=1 and snooze count < MAX_SNOOZE -> SNOOZE; load snz_timer = SNOOZE_MIN*60 (10 bits); snooze count +1.
  3. Snooze=1 with the count exhausted is ignored; stay RINGING.
  4. On Sec_Tick, ring_cnt +1. When ring_cnt == RING_SEC-1 on a Sec_Tick -> IDLE (auto-stop).
- SNOOZE, evaluated in this priority:
  1. Stop=1 or Alm_En=0 -> IDLE.
  2. On Sec_Tick, snz_timer -1. On the Sec_Tick where snz_timer == 1 -> RINGING; clear ring_cnt.
  - Snooze input is ignored in this state; holding Snooze does not extend it.
- Simultaneous events:
  - Stop wins over Snooze.
  - Stop wins over an auto-stop or snooze-expiry tick on the same Clk.
  - A trigger while already RINGING or SNOOZE is ignored.
- Outputs are registered and decoded from state, with 1-Clk latency from the causing edge.
  - Ringing = (state==RINGING); Snoozing = (state==SNOOZE).
  - Buzzer: see Optional Feature.
- Ring and snooze durations are in Sec_Tick units.
  - Ring lasts RING_SEC ticks after entry.
  - Snooze lasts exactly SNOOZE_MIN*60 ticks.
  - The first tick may arrive 0-1 s after entry; that phase error is accepted.

Optional Feature:
- Macro: ALARM_BEEP_EN.
- Defined:
  - A beep_ph flop toggles on each Sec_Tick while RINGING and is cleared on entry to RINGING.
  - Buzzer = Ringing & ~beep_ph, giving 1 s on / 1 s off starting "on".
- Undefined: Buzzer = Ringing, a steady tone; beep_ph logic is absent.

Test Plan:
- Reset, load 07:30, Alm_En=1, time steps 07:29->07:30 -> Ringing=1 and Buzzer=1 one Clk after the digits change; ALM_OUT = {2'd0,4'd7,3'd3,4'd0}.
- Ringing with RING_SEC=60 and no input -> Ringing drops on the 60th Sec_Tick; state IDLE; no retrigger while time stays 07:30.
- Snooze pressed while ringing, SNOOZE_MIN=5 -> Snoozing=1, Buzzer=0; re-ring exactly on the 300th Sec_Tick. After a 3rd snooze, a 4th Snooze press keeps Ringing=1.
- Snooze and Stop asserted on the same Clk while ringing -> IDLE; Ringing=0, Snoozing=0.
- Alm_En=0 at the match edge -> no ringing. Alm_En dropped during SNOOZE -> IDLE on the next Clk.
- Clr pulsed mid-RINGING between Clk edges -> Buzzer=0 immediately; ALM_OUT=0. Time 00:00 held with Alm_En=1 after reset -> no trigger. With ALARM_BEEP_EN defined -> Buzzer toggles each Sec_Tick while ringing.
